// File: rtl/rvcpu_pkg.sv
// Shared pipeline types for the rvcpu core: stage records, memory-op sizes, stage-mem FSM states.
// RVCPU_MISALIGN_TRAP_EN adds a misaligned flag to the writeback record.
package rvcpu;

  localparam int Width = 32;

  typedef struct packed {
    logic [Width-1:0] pc;
    logic [Width-1:0] data;
    logic [4:0]       rd;
    logic             rd_valid;
    logic             is_mem;
    logic [3:0]       op;
    logic [Width-1:0] addr;
  } stage_ex_t;

  typedef struct packed {
    logic [Width-1:0] pc;
    logic [4:0]       rd;
    logic             rd_valid;
    logic [Width-1:0] data;
`ifdef RVCPU_MISALIGN_TRAP_EN
    logic             misaligned;
`endif
  } stage_mem_t;

  typedef enum logic [2:0] {
    mem_b  = 3'd0,
    mem_h  = 3'd1,
    mem_w  = 3'd2,
    mem_bu = 3'd4,
    mem_hu = 3'd5
  } mem_size_t;

  typedef enum logic {mem_idle, mem_busy} mem_state_t;

  // Halfword needs a[0]=0, word needs a=0; byte accesses are never misaligned.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] a);
    case (f3[1:0])
      2'd1:    return a[0];
      2'd2:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory request/acknowledge port between the memory stage and the data memory.
interface stage_mem_if;
  import rvcpu::*;

  logic             dmem_req;
  logic             dmem_we;
  logic [Width-1:0] dmem_addr;
  logic [3:0]       dmem_be;
  logic [Width-1:0] dmem_wdata;
  logic [Width-1:0] dmem_rdata;
  logic             dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extraction with extension.
module mem_align
  import rvcpu::*;
(
  input  logic [2:0]       f3,
  input  logic [1:0]       a,
  input  logic [Width-1:0] sdata,
  input  logic [Width-1:0] rdata,
  output logic [3:0]       be,
  output logic [Width-1:0] wdata,
  output logic [Width-1:0] ldata
);

  mem_size_t sz;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sgn;

  assign sz  = mem_size_t'(f3);
  assign sgn = (sz == mem_b) || (sz == mem_h);

  always_comb begin
    lane_b = rdata[7:0];
    case (a)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = a[1] ? rdata[31:16] : rdata[15:0];
  end

  // Store encodings 4/5 fall into the B/H arms along with their load twins.
  always_comb begin
    be    = 4'hF;
    wdata = sdata;
    ldata = rdata;
    case (sz)
      mem_b, mem_bu: begin
        be    = 4'b0001 << a;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{sgn & lane_b[7]}}, lane_b};
      end
      mem_h, mem_hu: begin
        be    = 4'b0011 << {a[1], 1'b0};
        wdata = {2{sdata[15:0]}};
        ldata = {{16{sgn & lane_h[15]}}, lane_h};
      end
      default: begin
        be    = 4'hF;
        wdata = sdata;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: one-cycle pass-through for ALU results, req/ack transaction for loads/stores.
// RVCPU_MISALIGN_TRAP_EN turns misaligned accesses into an immediate faulting record instead of truncating.
module stage_mem
  import rvcpu::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  stage_ex_t   ex,
  stage_mem_if.master dmem,
  output logic        out_valid,
  output stage_mem_t  out
);

  mem_state_t       state;
  logic [Width-1:0] rq_pc;
  logic [4:0]       rq_rd;
  logic             rq_rd_valid;
  logic             rq_we;
  logic [2:0]       rq_f3;
  logic [1:0]       rq_a;

  logic             busy;
  logic             trap;
  logic [2:0]       al_f3;
  logic [1:0]       al_a;
  logic [3:0]       al_be;
  logic [Width-1:0] al_wdata;
  logic [Width-1:0] al_ldata;

  assign busy     = (state == mem_busy);
  assign in_ready = (state == mem_idle);

  // One aligner serves both phases: IDLE steers the incoming store, BUSY extracts the load.
  assign al_f3 = busy ? rq_f3 : ex.op[2:0];
  assign al_a  = busy ? rq_a  : ex.addr[1:0];

`ifdef RVCPU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(ex.op[2:0], ex.addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_align u_align (
    .f3    (al_f3),
    .a     (al_a),
    .sdata (ex.data),
    .rdata (dmem.dmem_rdata),
    .be    (al_be),
    .wdata (al_wdata),
    .ldata (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= mem_idle;
      out_valid       <= 1'b0;
      out             <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      rq_pc           <= '0;
      rq_rd           <= '0;
      rq_rd_valid     <= 1'b0;
      rq_we           <= 1'b0;
      rq_f3           <= '0;
      rq_a            <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        mem_idle: begin
          if (in_valid && !ex.is_mem) begin
            out.pc       <= ex.pc;
            out.rd       <= ex.rd;
            out.rd_valid <= ex.rd_valid;
            out.data     <= ex.data;
`ifdef RVCPU_MISALIGN_TRAP_EN
            out.misaligned <= 1'b0;
`endif
            out_valid    <= 1'b1;
          end else if (in_valid && trap) begin
            out.pc       <= ex.pc;
            out.rd       <= ex.rd;
            out.rd_valid <= 1'b0;
            out.data     <= ex.addr;
`ifdef RVCPU_MISALIGN_TRAP_EN
            out.misaligned <= 1'b1;
`endif
            out_valid    <= 1'b1;
          end else if (in_valid) begin
            rq_pc           <= ex.pc;
            rq_rd           <= ex.rd;
            rq_rd_valid     <= ex.rd_valid;
            rq_we           <= ex.op[3];
            rq_f3           <= ex.op[2:0];
            rq_a            <= ex.addr[1:0];
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ex.op[3];
            dmem.dmem_addr  <= {ex.addr[Width-1:2], 2'b00};
            dmem.dmem_be    <= al_be;
            dmem.dmem_wdata <= al_wdata;
            state           <= mem_busy;
          end
        end
        mem_busy: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            out.pc        <= rq_pc;
            out.rd        <= rq_rd;
            out.rd_valid  <= rq_rd_valid & ~rq_we;
            if (!rq_we) out.data <= al_ldata;
`ifdef RVCPU_MISALIGN_TRAP_EN
            out.misaligned <= 1'b0;
`endif
            out_valid     <= 1'b1;
            state         <= mem_idle;
          end
        end
        default: state <= mem_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed + randomized bench for stage_mem against an arithmetic lane model.
module tb_stage_mem;
  import rvcpu::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid;
  stage_ex_t  ex;
  stage_mem_t out;

  always #5 clk = ~clk;

  stage_mem_if dm();

  stage_mem dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ex        (ex),
    .dmem      (dm.master),
    .out_valid (out_valid),
    .out       (out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference lane model, written from the lane rules with plain arithmetic.
  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
    longint v;
    int a;
    a = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((rdata >> (8 * a)) % 256);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((rdata >> (16 * (a / 2))) % 65536);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_be(logic [2:0] f3, logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    case (f3[1:0])
      2'd0:    return 32'(1 << a);
      2'd1:    return 32'(3 << (2 * (a / 2)));
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'd0:    r = (d % 256) * 32'h01010101;
      2'd1:    r = (d % 65536) * 32'h00010001;
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic send(input stage_ex_t e, input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    ex       = e;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic alu_txn(input stage_ex_t e, input string tag);
    send(e, tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},      out.data, e.data);
    chk({tag, "_rd"},        32'(out.rd), 32'(e.rd));
    chk({tag, "_rd_valid"},  32'(out.rd_valid), 32'(e.rd_valid));
    chk({tag, "_pc"},        out.pc, e.pc);
    chk({tag, "_ready"},     32'(in_ready), 32'd1);
`ifdef RVCPU_MISALIGN_TRAP_EN
    chk({tag, "_misal"},     32'(out.misaligned), 32'd0);
`endif
    tick();
    chk({tag, "_pulse"},     32'(out_valid), 32'd0);
  endtask

  task automatic mem_txn(input stage_ex_t e, input int waitn, input logic [31:0] rdata, input string tag);
    logic st;
    st = e.op[3];
    send(e, tag);
    for (int k = 1; k <= waitn; k++) begin
      chk({tag, "_req"},   32'(dm.dmem_req), 32'd1);
      chk({tag, "_we"},    32'(dm.dmem_we), 32'(st));
      chk({tag, "_addr"},  dm.dmem_addr, e.addr - (e.addr % 4));
      chk({tag, "_be"},    32'(dm.dmem_be), ref_be(e.op[2:0], e.addr));
      if (st) chk({tag, "_wdata"}, dm.dmem_wdata, ref_wdata(e.op[2:0], e.data));
      chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
      if (k == waitn) begin
        dm.dmem_ack   = 1'b1;
        dm.dmem_rdata = rdata;
      end
      tick();
    end
    dm.dmem_ack   = 1'b0;
    dm.dmem_rdata = $urandom;
    chk({tag, "_req_drop"},  32'(dm.dmem_req), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"},        out.pc, e.pc);
    chk({tag, "_rd"},        32'(out.rd), 32'(e.rd));
    chk({tag, "_rd_valid"},  32'(out.rd_valid), st ? 32'd0 : 32'(e.rd_valid));
    if (!st) chk({tag, "_ldata"}, out.data, ref_load(e.op[2:0], e.addr, rdata));
`ifdef RVCPU_MISALIGN_TRAP_EN
    chk({tag, "_misal"},     32'(out.misaligned), 32'd0);
`endif
    tick();
    chk({tag, "_pulse"},     32'(out_valid), 32'd0);
  endtask

  function automatic stage_ex_t mk(logic is_mem, logic [3:0] op, logic [31:0] addr, logic [31:0] data);
    stage_ex_t e;
    e.pc       = $urandom;
    e.data     = data;
    e.rd       = 5'($urandom);
    e.rd_valid = 1'b1;
    e.is_mem   = is_mem;
    e.op       = op;
    e.addr     = addr;
    return e;
  endfunction

  initial begin
    stage_ex_t e;
    logic [2:0] f3;
    logic [2:0] f3_tab [5];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1; in_valid = 1'b0; ex = '0;
    dm.dmem_ack = 1'b0; dm.dmem_rdata = '0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req",       32'(dm.dmem_req), 32'd0);
    chk("rst_we",        32'(dm.dmem_we), 32'd0);
    chk("rst_addr",      dm.dmem_addr, 32'd0);
    chk("rst_be",        32'(dm.dmem_be), 32'd0);
    chk("rst_wdata",     dm.dmem_wdata, 32'd0);
    chk("rst_ready",     32'(in_ready), 32'd1);
    chk("rst_data",      out.data, 32'd0);
    chk("rst_pc",        out.pc, 32'd0);
    chk("rst_rd_valid",  32'(out.rd_valid), 32'd0);
    rst = 1'b0;
    tick();

    e = mk(1'b0, 4'h0, 32'h0, 32'h1234); e.rd = 5'd5;
    alu_txn(e, "alu");

    e = mk(1'b1, 4'b1000, 32'h1003, 32'h000000AB);
    mem_txn(e, 3, 32'h0, "sb");
    chk("sb_be_const",    32'(dm.dmem_be), 32'h8);
    chk("sb_wdata_const", dm.dmem_wdata, 32'hABABABAB);

    mem_txn(mk(1'b1, 4'h0, 32'h2002, 32'h0), 1, 32'h0080FF00, "lb2");
    mem_txn(mk(1'b1, 4'h4, 32'h2002, 32'h0), 1, 32'h0080FF00, "lbu2");
    mem_txn(mk(1'b1, 4'h0, 32'h2001, 32'h0), 2, 32'h0080FF00, "lb1");
    mem_txn(mk(1'b1, 4'h1, 32'h2002, 32'h0), 1, 32'h80010000, "lh");
    chk("lh_const", out.data, 32'hFFFF8001);
    mem_txn(mk(1'b1, 4'h5, 32'h2002, 32'h0), 1, 32'h80010000, "lhu");
    chk("lhu_const", out.data, 32'h00008001);

    // Ack while idle must not produce a record.
    dm.dmem_ack = 1'b1;
    tick();
    dm.dmem_ack = 1'b0;
    chk("idle_ack_valid", 32'(out_valid), 32'd0);
    chk("idle_ack_ready", 32'(in_ready), 32'd1);

    // Reset mid-transaction, then a late ack.
    send(mk(1'b1, 4'h2, 32'h4000, 32'h0), "rstbusy");
    tick();
    chk("rstbusy_req", 32'(dm.dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstbusy_req_drop", 32'(dm.dmem_req), 32'd0);
    chk("rstbusy_ready",    32'(in_ready), 32'd1);
    chk("rstbusy_valid",    32'(out_valid), 32'd0);
    dm.dmem_ack = 1'b1;
    tick();
    dm.dmem_ack = 1'b0;
    chk("late_ack_valid", 32'(out_valid), 32'd0);
    chk("late_ack_req",   32'(dm.dmem_req), 32'd0);
    chk("late_ack_ready", 32'(in_ready), 32'd1);

`ifdef RVCPU_MISALIGN_TRAP_EN
    e = mk(1'b1, 4'h2, 32'h3002, 32'h0);
    send(e, "trap");
    chk("trap_req",      32'(dm.dmem_req), 32'd0);
    chk("trap_valid",    32'(out_valid), 32'd1);
    chk("trap_misal",    32'(out.misaligned), 32'd1);
    chk("trap_rd_valid", 32'(out.rd_valid), 32'd0);
    chk("trap_data",     out.data, 32'h3002);
    tick();
    chk("trap_pulse",    32'(out_valid), 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      e  = mk(1'b1, 4'h0, $urandom, $urandom);
      e.rd_valid = 1'($urandom);
`ifdef RVCPU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'd1) e.addr[0] = 1'b0;
      if (f3[1:0] == 2'd2) e.addr[1:0] = 2'b00;
`endif
      case ($urandom_range(0, 2))
        0: begin
          e.is_mem = 1'b0;
          alu_txn(e, "rnd_alu");
        end
        1: begin
          e.op = {1'b0, f3};
          mem_txn(e, $urandom_range(1, 3), $urandom, "rnd_ld");
        end
        default: begin
          e.op = {1'b1, f3};
          mem_txn(e, $urandom_range(1, 3), $urandom, "rnd_st");
        end
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
